// File: rtl/max7219_rx.sv
// Receive-side MAX7219 serial decoder with a shadow register file, oversampled on clk.
// Optional daisy-chain output is built when MAX7219_RX_DOUT_EN is defined.
module max7219_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_clk,
  input  logic       seg_cs,
  input  logic       seg_din,
  output logic       seg_dout,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test
);

  // state | meaning
  // IDLE  | CS high, waiting for a CS falling edge
  // SHIFT | CS low, shifting in one bit per seg_clk rising edge
  // LATCH | one cycle: accept the frame (>= 16 bits) or flag it short
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_clk_d;
  logic                   r_cs_d;
  logic [15:0]            r_shreg;
  logic [4:0]             r_bit_cnt;
  logic [7:0]             r_regs [16];

  logic w_clk_s;
  logic w_cs_s;
  logic w_din_s;
  logic w_clk_rise;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_wr_ok;

  assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s    = r_din_sync[SYNC_STAGES-1];
  assign w_clk_rise = w_clk_s & ~r_clk_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;

  // Idle-level reset values keep reset release from looking like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_cs_sync  <= '1;
      r_din_sync <= '0;
      r_clk_d    <= 1'b1;
      r_cs_d     <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], seg_clk};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], seg_cs};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], seg_din};
      r_clk_d    <= w_clk_s;
      r_cs_d     <= w_cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= 16'h0000;
      r_bit_cnt   <= 5'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_addr  <= 4'h0;
      frame_data  <= 8'h00;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SHIFT;
            r_bit_cnt <= 5'd0;
          end
        end
        SHIFT: begin
          // A coincident CS rise still takes this last bit before latching
          if (w_clk_rise) begin
            r_shreg <= {r_shreg[14:0], w_din_s};
            if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
          end
          if (w_cs_rise) r_state <= LATCH;
        end
        LATCH: begin
          if (r_bit_cnt >= 5'd16) begin
            frame_valid <= 1'b1;
            frame_addr  <= r_shreg[11:8];
            frame_data  <= r_shreg[7:0];
          end else begin
            frame_err <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // No-op (0x0) and the unused 0xD/0xE slots are never written, so they read 0
  assign w_wr_ok = (frame_addr != 4'h0) && (frame_addr != 4'hD) && (frame_addr != 4'hE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= 8'h00;
      rd_data <= 8'h00;
    end else begin
      if (frame_valid && w_wr_ok) r_regs[frame_addr] <= frame_data;
      rd_data <= r_regs[rd_addr];
    end
  end

  assign decode_mode  = r_regs[9];
  assign intensity    = r_regs[10][3:0];
  assign scan_limit   = r_regs[11][2:0];
  assign shutdown_n   = r_regs[12][0];
  assign display_test = r_regs[15][0];

`ifdef MAX7219_RX_DOUT_EN
  logic w_clk_fall;
  logic r_dout;

  assign w_clk_fall = ~w_clk_s & r_clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 1'b0;
    end else if (r_state == SHIFT && w_clk_fall) begin
      r_dout <= r_shreg[15];
    end
  end

  assign seg_dout = r_dout;
`else
  logic w_unused;

  assign w_unused = r_shreg[15];
  assign seg_dout = 1'b0;
`endif

endmodule

// File: doc/max7219_rx.md
# max7219_rx

- Receive-side model of the MAX7219 serial interface, clocked entirely by the FPGA system clock.
- Oversamples `seg_clk`, `seg_cs` and `seg_din` from a MAX7219 driver and decodes each 16-bit frame into an address/data write.
- Maintains a shadow copy of the MAX7219 register file and exposes it for readback.
- Sits beside the display driver in loopback benches and in on-board capture/debug builds. It can also emulate a display chain element.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on each serial input. Legal values are 2–3.
- `clk` input, 1 bit: system clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `seg_clk` input, 1 bit: serial clock from the driver. Idles high.
- `seg_cs` input, 1 bit: LOAD/CS, active-low. A frame is latched on its rising edge.
- `seg_din` input, 1 bit: serial data, MSB first.
- `seg_dout` output, 1 bit: daisy-chain output (see Configuration).
- `frame_valid` output, 1 bit: one-cycle pulse when a frame is accepted.
- `frame_addr` output, 4 bits: bits [11:8] of the accepted frame.
- `frame_data` output, 8 bits: bits [7:0] of the accepted frame.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is rejected because it is shorter than 16 bits.
- `rd_addr` input, 4 bits: shadow register readback address.
- `rd_data` output, 8 bits: registered readback data.
- `decode_mode` output, 8 bits: live value of register 0x9.
- `intensity` output, 4 bits: register 0xA, bits [3:0].
- `scan_limit` output, 3 bits: register 0xB, bits [2:0].
- `shutdown_n` output, 1 bit: register 0xC, bit 0.
- `display_test` output, 1 bit: register 0xF, bit 0.

## Operation
- **Synchronizers.** Each input passes through `SYNC_STAGES` flops.
  - Reset values: `seg_clk` sync = 1, `seg_cs` sync = 1, `seg_din` sync = 0. Reset therefore never produces a false edge.
  - Edges are detected by comparing the last sync stage with a one-cycle-delayed copy.
- **State machine.**
  - `IDLE` → `SHIFT` on a falling edge of `seg_cs`. Entering `SHIFT` clears `bit_cnt` (5 bits).
  - `SHIFT`: on each rising edge of `seg_clk`, `shreg[15:0]` becomes {shreg[14:0], din}. `bit_cnt` increments and saturates at 31.
  - `SHIFT` → `LATCH` on a rising edge of `seg_cs`.
  - `LATCH` lasts one cycle, then returns to `IDLE`.
- **Coincident edges.** If a `seg_clk` rising edge and a `seg_cs` rising edge are detected in the same cycle, the shift happens first. The frame is then latched with the updated `shreg` and count.
- **LATCH with `bit_cnt` ≥ 16.**
  - Accept the frame: `frame_addr` = shreg[11:8], `frame_data` = shreg[7:0], and pulse `frame_valid`.
  - Frames longer than 16 bits keep only the last 16 received bits, as a MAX7219 does in a chain.
  - Bits [15:12] are don't-care.
- **LATCH with `bit_cnt` < 16.** Pulse `frame_err`. `frame_addr`/`frame_data` and the registers are unchanged.
- **Register file update**, in the same cycle as `frame_valid`:
  - Address 0x0 (no-op): no register write, but `frame_valid` still pulses.
  - Addresses 0x1–0x8: digit registers.
  - Addresses 0x9, 0xA, 0xB, 0xC, 0xF: full 8-bit store.
  - Addresses 0xD and 0xE: ignored, and reading them returns 0x00.
- **Edges while `seg_cs` is high.** `seg_clk` edges outside a frame are ignored. A `seg_cs` rising edge seen while `IDLE` does nothing.
- **Reset values.**
  - All registers are 0x00. This means shutdown mode and decode off.
  - State is `IDLE`, `shreg` = 0, `bit_cnt` = 0.
  - `frame_valid`, `frame_err`, `seg_dout` and `rd_data` are 0.
- **Reset mid-frame.** The partial frame is discarded. No pulse is generated on or after reset release.

## Timing
- **Input pacing.** High and low phases of `seg_clk` must each be ≥ `SYNC_STAGES`+1 clk cycles. CS high time must meet the same bound. Faster inputs are out of spec.
- **Input-to-pulse latency.** The cycle with `frame_valid`/`frame_err` high is `SYNC_STAGES`+2 cycles after the `seg_cs` rising edge at the pin.
- **Field updates.** `frame_addr`/`frame_data` update in the `frame_valid` cycle and hold until the next accepted frame.
- **Register field outputs.** `decode_mode`, `intensity`, `scan_limit`, `shutdown_n` and `display_test` reflect a write one cycle after `frame_valid`.
- **Readback.** `rd_data` is registered with 1-cycle latency from `rd_addr`. A read of the address being written in the same cycle returns the old value.

## Configuration
- Macro: `MAX7219_RX_DOUT_EN`.
- **Defined:**
  - `seg_dout` is registered and updated on each `seg_clk` falling edge during `SHIFT`.
  - Its value is shreg[15], which is `seg_din` delayed by 16 clocks, matching MAX7219 DOUT.
  - It holds its value outside `SHIFT`.
- **Undefined:** `seg_dout` is tied to 0 and no falling-edge logic is built.

## Test plan
- Single-register write: frame 0x0C01 → `frame_valid` pulses once, `frame_addr`=0xC, `frame_data`=0x01, and `shutdown_n`=1 on the next cycle.
- Full init sequence of addresses 0x9, 0xA, 0xB, 0xC, 0xF and digits 1–8, with data 0x01–0x08 on the digits and 0xFF, 0x03, 0x07, 0x01, 0x00 on the control registers.
  - Read back each address via `rd_addr` and check the value, with 1-cycle latency.
  - 0xD reads 0x00.
- Short frame: CS low, 12 clocks, CS high → `frame_err` pulses once, no `frame_valid`, and registers unchanged.
- 32-bit chained frame 0x0A05_0B02 → only 0x0B02 is applied: `scan_limit`=2 and `intensity` unchanged. With `MAX7219_RX_DOUT_EN`, `seg_dout` reproduces 0x0A05 MSB-first on clocks 17–32.
- No-op frame 0x00AA → `frame_valid`=1 with `frame_addr`=0, and no register changes.
- Assert `rst_n` after 8 bits of frame 0x0155, then release and send 0x0233.
  - No pulse for the aborted frame.
  - Digit 1 = 0x00 and digit 2 = 0x33.
